fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the shared synchronous FIFO.
// Bounded bursts per grant, writes gated by the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = 5;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]       pick;
  logic                  found;
  logic                  in_grant;
  logic                  sel_valid;
  logic                  beat;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    idx;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && idx == j && req_valid[j]) begin
          found = 1'b1;
          pick  = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    in_grant  = (state_q == GRANT);
    sel_valid = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        if (in_grant) begin
          req_ready[i] = !fifo_full;
        end
      end
    end
    beat       = in_grant && sel_valid && !fifo_full;
    fifo_wr_cs = in_grant;
    busy       = in_grant;
    fifo_wr_en = beat;
    fifo_data  = beat ? sel_data : '0;
    grant_id   = grant_id_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!sel_valid) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else if (beat) begin
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            last_grant_d = grant_id_q;
            state_d      = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: default 4-req build plus
// a 2-req single-beat build.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        wr_cs, wr_en;
  logic [7:0]  fifo_data;
  logic [2:0]  grant_id;
  logic        busy;

  logic [1:0]  r2_valid;
  logic [15:0] r2_data;
  logic [1:0]  r2_ready;
  logic        wr_cs2, wr_en2, busy2;
  logic [7:0]  data2;
  logic [0:0]  gid2;

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_cs(wr_cs), .fifo_wr_en(wr_en),
    .fifo_data(fifo_data), .grant_id(grant_id),
    .busy(busy)
  );

  fifo_wr_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8),
    .MAX_BURST(1), .ID_W(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r2_valid), .req_data(r2_data),
    .req_ready(r2_ready), .fifo_full(1'b0),
    .fifo_wr_cs(wr_cs2), .fifo_wr_en(wr_en2),
    .fifo_data(data2), .grant_id(gid2),
    .busy(busy2)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] src [4][$];
  logic [7:0] exp_d [$];
  logic [2:0] exp_g [$];
  int wr_cyc [$];
  int cyc = 0;
  int wr_cnt = 0;
  logic busy_prev = 1'b0;
  logic [3:0] last_ready;
  logic last_busy, last_en;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = src[i].size() > 0;
      req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
  endtask

  task automatic cycle();
    logic [3:0] hs;
    @(negedge clk);
    cyc++;
    last_ready = req_ready;
    last_busy  = busy;
    last_en    = wr_en;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (fifo_full) chk("wr_while_full", 32'(wr_en), 0);
    if (busy && !busy_prev) begin
      chk("grant_pending", 32'(exp_g.size() > 0), 1);
      if (exp_g.size() > 0) chk("grant_id", 32'(grant_id), 32'(exp_g.pop_front()));
    end
    busy_prev = busy;
    if (wr_en) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      chk("write_pending", 32'(exp_d.size() > 0), 1);
      if (exp_d.size() > 0) chk("fifo_data", 32'(fifo_data), 32'(exp_d.pop_front()));
    end
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) src[i].delete(0);
    drive();
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    chk("writes_in_budget", wr_cnt, target);
  endtask

  task automatic drain(input int target);
    repeat (4) cycle();
    chk("writes_total", wr_cnt, target);
    chk("exp_data_left", exp_d.size(), 0);
    chk("exp_grant_left", exp_g.size(), 0);
  endtask

  task automatic do_reset();
    fifo_full = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_d.delete();
    exp_g.delete();
    wr_cyc.delete();
    wr_cnt = 0;
    busy_prev = 1'b0;
    drive();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_cs", 32'(wr_cs), 0);
    chk("rst_en", 32'(wr_en), 0);
    chk("rst_data", 32'(fifo_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_en2", 32'(wr_en2), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    r2_valid = 2'b11;
    r2_data  = {8'hA1, 8'hA0};
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;
    #2;

    // single requester: two bursts of 4 with one bubble
    do_reset();
    for (int k = 0; k < 8; k++) begin
      src[0].push_back(8'(8'h10 + k));
      exp_d.push_back(8'(8'h10 + k));
    end
    exp_g.push_back(3'd0);
    exp_g.push_back(3'd0);
    drive();
    run_until(8, 40);
    if (wr_cyc.size() >= 8) begin
      chk("t1_back2back", wr_cyc[3] - wr_cyc[0], 3);
      chk("t1_bubble", wr_cyc[4] - wr_cyc[3], 2);
    end
    drain(8);

    // all four valid: round robin 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++)
        src[r].push_back(8'(8'h40 + r*16 + k));
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < 4; r++) begin
        exp_g.push_back(3'(r));
        for (int k = 0; k < 4; k++)
          exp_d.push_back(8'(8'h40 + r*16 + rnd*4 + k));
      end
    drive();
    run_until(32, 100);
    if (wr_cyc.size() >= 32) chk("t2_bubble", wr_cyc[4] - wr_cyc[3], 2);
    drain(32);

    // full stall after two beats
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src[2].push_back(8'(8'h80 + k));
      exp_d.push_back(8'(8'h80 + k));
    end
    exp_g.push_back(3'd2);
    drive();
    run_until(2, 20);
    fifo_full = 1'b1;
    repeat (5) begin
      cycle();
      chk("t3_ready", 32'(last_ready), 0);
      chk("t3_busy", 32'(last_busy), 1);
      chk("t3_en", 32'(last_en), 0);
    end
    fifo_full = 1'b0;
    run_until(4, 20);
    drain(4);

    // requester 1 drops valid, requester 3 next
    do_reset();
    src[1].push_back(8'h91);
    src[1].push_back(8'h92);
    for (int k = 0; k < 4; k++) src[3].push_back(8'(8'hB0 + k));
    exp_d.push_back(8'h91);
    exp_d.push_back(8'h92);
    for (int k = 0; k < 4; k++) exp_d.push_back(8'(8'hB0 + k));
    exp_g.push_back(3'd1);
    exp_g.push_back(3'd3);
    drive();
    run_until(6, 30);
    drain(6);

    // asynchronous reset pulse mid-burst
    do_reset();
    for (int k = 0; k < 8; k++) src[0].push_back(8'(8'hC0 + k));
    exp_d.push_back(8'hC0);
    exp_d.push_back(8'hC1);
    exp_g.push_back(3'd0);
    drive();
    run_until(2, 20);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", 32'(wr_cs), 0);
    chk("t5_en", 32'(wr_en), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_data", 32'(fifo_data), 0);
    #2;
    rst_n = 1'b1;
    exp_d.delete();
    exp_g.delete();
    wr_cyc.delete();
    wr_cnt = 0;
    busy_prev = 1'b0;
    for (int k = 2; k < 8; k++) exp_d.push_back(8'(8'hC0 + k));
    exp_g.push_back(3'd0);
    exp_g.push_back(3'd0);
    run_until(6, 30);
    if (wr_cyc.size() >= 6) begin
      chk("t5_burst_len", wr_cyc[3] - wr_cyc[0], 3);
      chk("t5_bubble", wr_cyc[4] - wr_cyc[3], 2);
    end
    drain(6);

    // MAX_BURST=1, two requesters alternate
    do_reset();
    begin
      logic [7:0] e2 [$];
      int n2 = 0;
      int c = 0;
      int last = -1;
      for (int k = 0; k < 3; k++) begin
        e2.push_back(8'hA0);
        e2.push_back(8'hA1);
      end
      while (n2 < 6 && c < 30) begin
        @(negedge clk);
        c++;
        chk("t6_onehot", 32'($countones(r2_ready) <= 1), 1);
        if (wr_en2) begin
          if (e2.size() > 0) chk("t6_data", 32'(data2), 32'(e2.pop_front()));
          if (last >= 0) chk("t6_gap", c - last, 2);
          last = c;
          n2++;
        end
      end
      chk("t6_writes", n2, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
